// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared widths and round/saturate helpers for the IIR filter family
package iir_pkg;

    localparam int IIR_WIDTH_H    = 15;
    localparam int IIR_WIDTH_W    = 10;
    localparam int IIR_WIDTH_O    = 12;
    localparam int IIR_FIFO_DEPTH = 8;

    // Saturation result: the clipped value plus whether clipping happened.
    typedef struct packed {
        logic               clipped;
        logic signed [63:0] value;
    } sat_result_t;

    // Round half toward +inf, then drop frac_w fractional bits.
    // The 64-bit working width is far wider than any sample, so the bias add cannot overflow.
    function automatic logic signed [63:0] round_half_up(
        input logic signed [63:0] x,
        input int                 frac_w
    );
        logic signed [63:0] bias;
        bias = 64'sd1 <<< (frac_w - 1);
        return (x + bias) >>> frac_w;
    endfunction

    // Clip to the two's complement range of an out_w-bit integer.
    function automatic sat_result_t saturate(
        input logic signed [63:0] x,
        input int                 out_w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_result_t        r;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        r.clipped = 1'b1;
        if (x > hi) begin
            r.value = hi;
        end else if (x < lo) begin
            r.value = lo;
        end else begin
            r.value   = x;
            r.clipped = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_sync_fifo.sv
// rtl/iir_sync_fifo.sv - synchronous FIFO with registered show-ahead output
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_push, i_din   write request and data; ignored when full unless a pop happens on the same edge
//   i_pop           consume the displayed head; ignored while o_dout_valid is low
//   o_dout          registered head of the FIFO
//   o_dout_valid    o_dout holds an entry
//   o_full, o_empty occupancy flags
//   o_level         occupancy 0..DEPTH (the displayed head counts until popped)
module iir_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_dout_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;

    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic [LW-1:0]    w_level_after_pop;

    assign w_full            = (r_level == LW'(DEPTH));
    assign w_pop             = i_pop & r_dout_valid;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_push            = i_push & (~w_full | w_pop);
    assign w_rd_ptr_nxt      = r_rd_ptr + AW'(w_pop);
    assign w_level_after_pop = r_level - LW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // The output register looks at the post-pop, pre-push state, so a write
    // into an empty FIFO becomes visible one edge later (no bypass path).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_level      <= w_level_after_pop + LW'(w_push);
            r_dout_valid <= (w_level_after_pop != '0);
            if (w_level_after_pop != '0) begin
                r_dout <= r_mem[w_rd_ptr_nxt];
            end
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_full       = w_full;
    assign o_empty      = (r_level == '0);
    assign o_level      = r_level;

endmodule

// File: rtl/iir_out_conv.sv
// rtl/iir_out_conv.sv - round, saturate and buffer the IIR filter output stream
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   data_i_en, data_i       filter sample strobe and Q(width_H.width_W) sample
//   data_o_valid/ready      downstream handshake
//   data_o                  rounded, saturated width_O-bit sample
//   sat_flag                sticky clip indicator
//   drop_cnt                saturating count of samples lost to a full FIFO
//   level                   FIFO occupancy
module iir_out_conv
    import iir_pkg::*;
#(
    parameter int width_H = IIR_WIDTH_H,
    parameter int width_W = IIR_WIDTH_W,
    parameter int width_O = IIR_WIDTH_O,
    parameter int DEPTH   = IIR_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              data_i_en,
    input  logic signed [width_H+width_W-1:0] data_i,
    output logic                              data_o_valid,
    input  logic                              data_o_ready,
    output logic signed [width_O-1:0]         data_o,
    output logic                              sat_flag,
    output logic [15:0]                       drop_cnt,
    output logic [$clog2(DEPTH):0]            level
);

    localparam int RW = width_H + 1;

    logic signed [RW-1:0]      r_r_data;
    logic                      r_r_valid;
    logic signed [width_O-1:0] r_s_data;
    logic                      r_s_valid;
    logic                      r_sat_flag;
    logic [15:0]               r_drop_cnt;

    logic signed [63:0]        w_round_full;
    logic signed [RW-1:0]      w_round;
    logic [63-RW:0]            w_unused_round_hi;
    sat_result_t               w_sat;
    logic [63-width_O:0]       w_unused_sat_hi;
    logic                      w_full;
    logic                      w_unused_empty;
    logic                      w_drop;

    // The rounded value always fits in width_H+1 bits; the upper bits are pure sign.
    assign w_round_full      = round_half_up(64'(data_i), width_W);
    assign w_round           = w_round_full[RW-1:0];
    assign w_unused_round_hi = w_round_full[63:RW];

    assign w_sat             = saturate(64'(r_r_data), width_O);
    assign w_unused_sat_hi   = w_sat.value[63:width_O];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r_valid  <= 1'b0;
            r_r_data   <= '0;
            r_s_valid  <= 1'b0;
            r_s_data   <= '0;
            r_sat_flag <= 1'b0;
        end else begin
            r_r_valid <= data_i_en;
            if (data_i_en) begin
                r_r_data <= w_round;
            end
            r_s_valid <= r_r_valid;
            if (r_r_valid) begin
                r_s_data <= w_sat.value[width_O-1:0];
                if (w_sat.clipped) begin
                    r_sat_flag <= 1'b1;
                end
            end
        end
    end

    // The filter cannot be stalled, so a write into a full FIFO with no
    // departing head is lost and only counted.
    assign w_drop = r_s_valid & w_full & ~(data_o_valid & data_o_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    iir_sync_fifo #(
        .WIDTH (width_O),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (r_s_valid),
        .i_din        (r_s_data),
        .i_pop        (data_o_ready),
        .o_dout       (data_o),
        .o_dout_valid (data_o_valid),
        .o_full       (w_full),
        .o_empty      (w_unused_empty),
        .o_level      (level)
    );

    assign sat_flag = r_sat_flag;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_iir_out_conv.sv
// tb/tb_iir_out_conv.sv - self-checking bench for iir_out_conv
module tb_iir_out_conv;

    logic               clk;
    logic               rst_n;
    logic               data_i_en;
    logic signed [24:0] data_i;
    logic               data_o_valid;
    logic               data_o_ready;
    logic signed [11:0] data_o;
    logic               sat_flag;
    logic [15:0]        drop_cnt;
    logic [3:0]         level;

    int     n_checks = 0;
    int     n_errors = 0;
    int     n_xfer   = 0;
    int     n_sent   = 0;
    longint exp_q[$];

    iir_out_conv #(
        .width_H (15),
        .width_W (10),
        .width_O (12),
        .DEPTH   (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_i_en    (data_i_en),
        .data_i       (data_i),
        .data_o_valid (data_o_valid),
        .data_o_ready (data_o_ready),
        .data_o       (data_o),
        .sat_flag     (sat_flag),
        .drop_cnt     (drop_cnt),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: real-valued floor(x/2^10 + 0.5), then clip to 12 bits.
    function automatic longint model(input longint x);
        real    r;
        longint v;
        r = $floor(real'(x) / 1024.0 + 0.5);
        v = longint'(r);
        if (v > 2047)  v = 2047;
        if (v < -2048) v = -2048;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input longint x, input bit keep, input longint exp);
        data_i    = 25'(x);
        data_i_en = 1'b1;
        n_sent++;
        if (keep) exp_q.push_back(exp);
        tick();
        data_i_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk(tag, exp_q.size(), 0);
        tick();
        tick();
    endtask

    // Scoreboard monitor: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && data_o_valid && data_o_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", longint'(data_o), -99999);
            end else begin
                chk("data_o", longint'(data_o), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        data_i_en    = 1'b0;
        data_i       = '0;
        data_o_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", data_o_valid, 0);
        chk("rst_data",  longint'(data_o), 0);
        chk("rst_sat",   sat_flag, 0);
        chk("rst_drop",  drop_cnt, 0);
        chk("rst_level", level, 0);
        rst_n = 1'b1;
        tick();

        // Rounding and 3-cycle latency
        data_o_ready = 1'b1;
        strobe(1536, 1, 2);
        tick(); tick();
        chk("lat_pre_1536", data_o_valid, 0);
        tick();
        chk("lat_1536", data_o_valid, 1);
        tick(); tick();
        strobe(-1536, 1, -1);
        tick(); tick();
        chk("lat_pre_m1536", data_o_valid, 0);
        tick();
        chk("lat_m1536", data_o_valid, 1);
        tick(); tick();
        strobe(512, 1, 1);
        tick(); tick(); tick();
        chk("lat_512", data_o_valid, 1);
        tick(); tick();
        strobe(-513, 1, -1);
        tick(); tick(); tick();
        chk("lat_m513", data_o_valid, 1);
        tick(); tick();
        strobe(511, 1, 0);
        tick(); tick(); tick();
        chk("lat_511", data_o_valid, 1);
        drain("drain_round");
        chk("sat_after_round", sat_flag, 0);

        // Saturation
        strobe(5000 * 1024, 1, 2047);
        strobe(-5000 * 1024, 1, -2048);
        strobe(100 * 1024, 1, 100);
        drain("drain_sat");
        chk("sat_sticky", sat_flag, 1);

        // Backpressure: 10 strobes into 8 entries
        data_o_ready = 1'b0;
        for (int k = 1; k <= 10; k++) strobe(k * 1024, k <= 8, k);
        tick(); tick();
        chk("bp_level", level, 8);
        chk("bp_drop",  drop_cnt, 2);
        chk("bp_valid", data_o_valid, 1);
        data_o_ready = 1'b1;
        drain("drain_bp");
        chk("bp_drop_after", drop_cnt, 2);
        chk("bp_level_after", level, 0);

        // Full FIFO with simultaneous pop
        data_o_ready = 1'b0;
        for (int k = 20; k < 28; k++) strobe(k * 1024, 1, k);
        tick(); tick();
        chk("fullpop_level_pre", level, 8);
        strobe(28 * 1024, 1, 28);
        tick();
        data_o_ready = 1'b1;
        tick();
        chk("fullpop_level", level, 8);
        chk("fullpop_drop",  drop_cnt, 2);
        drain("drain_fullpop");

        // Reset with 4 buffered and 2 in flight
        data_o_ready = 1'b0;
        for (int k = 1; k <= 6; k++) strobe(-5000 * 1024, 0, 0);
        chk("pre_rst_level", level, 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", data_o_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_sat",   sat_flag, 0);
        chk("mid_rst_drop",  drop_cnt, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        data_o_ready = 1'b1;
        strobe(7 * 1024, 1, 7);
        tick(); tick();
        chk("post_rst_lat_pre", data_o_valid, 0);
        tick();
        chk("post_rst_lat", data_o_valid, 1);
        drain("drain_rst");

        // Random streaming; ready is forced high when many samples are outstanding
        n_sent = 0;
        n_xfer = 0;
        for (int c = 0; c < 1000; c++) begin
            longint x;
            x = longint'($signed(25'($urandom))) >>> $urandom_range(0, 4);
            if ((n_sent - n_xfer) >= 6) data_o_ready = 1'b1;
            else                        data_o_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1) begin
                data_i    = 25'(x);
                data_i_en = 1'b1;
                n_sent++;
                exp_q.push_back(model(x));
            end else begin
                data_i_en = 1'b0;
            end
            tick();
        end
        data_i_en    = 1'b0;
        data_o_ready = 1'b1;
        drain("drain_random");
        chk("random_drop", drop_cnt, 0);
        chk("random_level", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
